kf8288_ws_bus_controller: RTL and testbench

Parametrised bus-cycle controller, the next generation of the 8288-like bus controller in the KFPC-XT chipset. It decodes S2..S0 processor status and runs an explicit T1/T2/T3/Tw/T4 state machine. It inserts a programmable number of wait states per cycle class (memory, I/O, INTA), extends cycles on an external `ready` input, and drives `cpu_ready` back to the CPU. The block sits between the CPU status pins and the system command bus, and replaces the fixed-timing controller where slow peripherals need wait states.

---
 rtl/kf8288_ws_bus_controller.sv | 207 ++++++++++++++++++++
 tb/tb_kf8288_ws_bus_controller.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf8288_ws_bus_controller.sv
// kf8288_ws_bus_controller
// Bus-cycle controller with programmable wait states. Decodes S2..S0, runs a
// T1/T2/T3/Tw/T4 sequence advanced on rising edges of cpu_clock (sampled on
// clock), inserts per-class wait states, stretches on ready and drives the
// command bus and transceiver controls.
//
// Ports:
//   clock, reset_n                      system clock, async active-low reset
//   cpu_clock                           CPU clock level, edge-detected here
//   address_enable_n, command_enable,
//   io_bus_mode                         AEN#, CEN, IOB
//   processor_status[2:0]               S2..S0 (111 = passive, 011 = halt)
//   ready                               peripheral ready
//   enable_io_command,
//   enable_memory_command               command-bus enables (combinational)
//   *_command_n, interrupt_acknowledge_n active-low commands
//   direction_transmit_or_receive_n, data_enable, peripheral_data_enable_n,
//   master_cascade_enable, address_latch_enable   transceiver/latch control
//   cpu_ready                           READY to the CPU (combinational)
//   bus_state[2:0]                      IDLE=0 T1=1 T2=2 T3=3 TW=4 T4=5
//   cycle_done                          one-clock pulse on entry to T4
module kf8288_ws_bus_controller #(
  parameter int unsigned MEM_WAIT_STATES    = 0,
  parameter int unsigned IO_WAIT_STATES     = 1,
  parameter int unsigned INTA_WAIT_STATES   = 1,
  parameter int unsigned WAIT_COUNTER_WIDTH = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cpu_clock,
  input  logic       address_enable_n,
  input  logic       command_enable,
  input  logic       io_bus_mode,
  input  logic [2:0] processor_status,
  input  logic       ready,
  output logic       enable_io_command,
  output logic       enable_memory_command,
  output logic       io_read_command_n,
  output logic       io_write_command_n,
  output logic       advanced_io_write_command_n,
  output logic       interrupt_acknowledge_n,
  output logic       memory_read_command_n,
  output logic       memory_write_command_n,
  output logic       advanced_memory_write_command_n,
  output logic       direction_transmit_or_receive_n,
  output logic       data_enable,
  output logic       peripheral_data_enable_n,
  output logic       master_cascade_enable,
  output logic       address_latch_enable,
  output logic       cpu_ready,
  output logic [2:0] bus_state,
  output logic       cycle_done
);

  localparam int unsigned CW = WAIT_COUNTER_WIDTH;

  localparam logic [2:0] ST_INTA    = 3'b000;
  localparam logic [2:0] ST_IOR     = 3'b001;
  localparam logic [2:0] ST_IOW     = 3'b010;
  localparam logic [2:0] ST_HALT    = 3'b011;
  localparam logic [2:0] ST_CODE    = 3'b100;
  localparam logic [2:0] ST_MEMR    = 3'b101;
  localparam logic [2:0] ST_MEMW    = 3'b110;
  localparam logic [2:0] ST_PASSIVE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_TW   = 3'd4,
    S_T4   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    status_q, status_d;
  logic [CW-1:0] count_q, count_d;
  logic          dt_r_n_q, dt_r_n_d;
  logic          ale_q, ale_d;
  logic          mce_q, mce_d;
  logic          de_q, de_d;
  logic          done_q, done_d;
  logic          prev_cpu_clock;

  logic          cpu_posedge_c;
  logic          start_c;
  logic          receive_c;
  logic [CW-1:0] wait_load_c;
  logic          cmd_early_c;
  logic          cmd_late_c;
  logic          mem_gate_c;
  logic          io_gate_c;

  assign cpu_posedge_c = cpu_clock & ~prev_cpu_clock;
  assign start_c       = (processor_status != ST_HALT) && (processor_status != ST_PASSIVE);
  assign receive_c     = (processor_status == ST_INTA) || (processor_status == ST_IOR) ||
                         (processor_status == ST_CODE) || (processor_status == ST_MEMR);

  // Wait-state count for the class latched at T1.
  always_comb begin
    wait_load_c = '0;
    case (status_q)
      ST_CODE, ST_MEMR, ST_MEMW: wait_load_c = CW'(MEM_WAIT_STATES);
      ST_IOR, ST_IOW:            wait_load_c = CW'(IO_WAIT_STATES);
      ST_INTA:                   wait_load_c = CW'(INTA_WAIT_STATES);
      default:                   wait_load_c = '0;
    endcase
  end

  // Next-state and next registered-output logic.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    count_d  = count_q;
    dt_r_n_d = dt_r_n_q;
    if (cpu_posedge_c) begin
      case (state_q)
        S_IDLE, S_T4: begin
          if (start_c) begin
            state_d  = S_T1;
            status_d = processor_status;
            dt_r_n_d = ~receive_c;
          end else begin
            state_d  = S_IDLE;
            dt_r_n_d = 1'b1;
          end
        end
        S_T1: state_d = S_T2;
        S_T2: begin
          state_d = S_T3;
          count_d = wait_load_c;
        end
        S_T3, S_TW: begin
          // Programmed waits run first; ready is only honoured once they expire.
          if (count_q != '0) begin
            state_d = S_TW;
            count_d = count_q - CW'(1);
          end else if (ready) begin
            state_d = S_T4;
          end else begin
            state_d = S_TW;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    ale_d  = (state_d == S_T1);
    mce_d  = (state_d == S_T1) && (status_d == ST_INTA);
    de_d   = (state_d == S_T2) || (state_d == S_T3) || (state_d == S_TW);
    done_d = (state_d == S_T4) && (state_q != S_T4);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      status_q       <= ST_PASSIVE;
      count_q        <= '0;
      dt_r_n_q       <= 1'b1;
      ale_q          <= 1'b0;
      mce_q          <= 1'b0;
      de_q           <= 1'b0;
      done_q         <= 1'b0;
      prev_cpu_clock <= 1'b0;
    end else begin
      state_q        <= state_d;
      status_q       <= status_d;
      count_q        <= count_d;
      dt_r_n_q       <= dt_r_n_d;
      ale_q          <= ale_d;
      mce_q          <= mce_d;
      de_q           <= de_d;
      done_q         <= done_d;
      prev_cpu_clock <= cpu_clock;
    end
  end

  // Commands decode only from registers plus the static gating inputs.
  assign cmd_early_c = (state_q == S_T2) || (state_q == S_T3) || (state_q == S_TW);
  assign cmd_late_c  = (state_q == S_T3) || (state_q == S_TW);
  assign mem_gate_c  = command_enable;
  assign io_gate_c   = command_enable | io_bus_mode;

  assign memory_read_command_n           = ~(cmd_early_c & mem_gate_c &
                                             ((status_q == ST_CODE) | (status_q == ST_MEMR)));
  assign memory_write_command_n          = ~(cmd_late_c  & mem_gate_c & (status_q == ST_MEMW));
  assign advanced_memory_write_command_n = ~(cmd_early_c & mem_gate_c & (status_q == ST_MEMW));
  assign io_read_command_n               = ~(cmd_early_c & io_gate_c  & (status_q == ST_IOR));
  assign io_write_command_n              = ~(cmd_late_c  & io_gate_c  & (status_q == ST_IOW));
  assign advanced_io_write_command_n     = ~(cmd_early_c & io_gate_c  & (status_q == ST_IOW));
  assign interrupt_acknowledge_n         = ~(cmd_early_c & io_gate_c  & (status_q == ST_INTA));

  assign enable_memory_command = ~address_enable_n;
  assign enable_io_command     = ~address_enable_n | io_bus_mode;

  // CPU is held while waits remain or the peripheral is not ready.
  assign cpu_ready = ~(cmd_late_c & ((count_q != '0) | ~ready));

  assign direction_transmit_or_receive_n = dt_r_n_q;
  assign data_enable                     = de_q;
  assign peripheral_data_enable_n        = ~de_q;
  assign master_cascade_enable           = mce_q;
  assign address_latch_enable            = ale_q;
  assign bus_state                       = state_q;
  assign cycle_done                      = done_q;

endmodule

// File: tb/tb_kf8288_ws_bus_controller.sv
// Bench for kf8288_ws_bus_controller: directed bus cycles plus random status,
// ready and gating, checked against a cycle-position model.
module tb_kf8288_ws_bus_controller;

  localparam int MEM_WS  = 0;
  localparam int IO_WS   = 1;
  localparam int INTA_WS = 1;

  logic       clock;
  logic       reset_n;
  logic       cpu_clock;
  logic       address_enable_n;
  logic       command_enable;
  logic       io_bus_mode;
  logic [2:0] processor_status;
  logic       ready;
  logic       enable_io_command;
  logic       enable_memory_command;
  logic       io_read_command_n;
  logic       io_write_command_n;
  logic       advanced_io_write_command_n;
  logic       interrupt_acknowledge_n;
  logic       memory_read_command_n;
  logic       memory_write_command_n;
  logic       advanced_memory_write_command_n;
  logic       direction_transmit_or_receive_n;
  logic       data_enable;
  logic       peripheral_data_enable_n;
  logic       master_cascade_enable;
  logic       address_latch_enable;
  logic       cpu_ready;
  logic [2:0] bus_state;
  logic       cycle_done;

  kf8288_ws_bus_controller #(
    .MEM_WAIT_STATES   (MEM_WS),
    .IO_WAIT_STATES    (IO_WS),
    .INTA_WAIT_STATES  (INTA_WS),
    .WAIT_COUNTER_WIDTH(3)
  ) dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .cpu_clock                      (cpu_clock),
    .address_enable_n               (address_enable_n),
    .command_enable                 (command_enable),
    .io_bus_mode                    (io_bus_mode),
    .processor_status               (processor_status),
    .ready                          (ready),
    .enable_io_command              (enable_io_command),
    .enable_memory_command          (enable_memory_command),
    .io_read_command_n              (io_read_command_n),
    .io_write_command_n             (io_write_command_n),
    .advanced_io_write_command_n    (advanced_io_write_command_n),
    .interrupt_acknowledge_n        (interrupt_acknowledge_n),
    .memory_read_command_n          (memory_read_command_n),
    .memory_write_command_n         (memory_write_command_n),
    .advanced_memory_write_command_n(advanced_memory_write_command_n),
    .direction_transmit_or_receive_n(direction_transmit_or_receive_n),
    .data_enable                    (data_enable),
    .peripheral_data_enable_n       (peripheral_data_enable_n),
    .master_cascade_enable          (master_cascade_enable),
    .address_latch_enable           (address_latch_enable),
    .cpu_ready                      (cpu_ready),
    .bus_state                      (bus_state),
    .cycle_done                     (cycle_done)
  );

  // Bit 6..0: MRDC, MWTC, AMWC, IORC, IOWC, AIOWC, INTA (all active-low)
  logic [6:0] cmds;
  assign cmds = {memory_read_command_n, memory_write_command_n, advanced_memory_write_command_n,
                 io_read_command_n, io_write_command_n, advanced_io_write_command_n,
                 interrupt_acknowledge_n};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: position within the current bus cycle (0 = T1 period).
  int         m_state = 0;
  int         m_pos   = 0;
  logic [2:0] m_cls   = 3'b111;
  logic       m_dtr   = 1'b1;
  logic       m_done  = 1'b0;

  function automatic int waits_for(input logic [2:0] c);
    case (c)
      3'b100, 3'b101, 3'b110: return MEM_WS;
      3'b001, 3'b010:         return IO_WS;
      3'b000:                 return INTA_WS;
      default:                return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pos   = 0;
    m_cls   = 3'b111;
    m_dtr   = 1'b1;
    m_done  = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] st, input logic rdy);
    int prev;
    prev = m_state;
    if (m_state == 0 || m_state == 5) begin
      if (st != 3'b011 && st != 3'b111) begin
        m_state = 1;
        m_pos   = 0;
        m_cls   = st;
        m_dtr   = (st == 3'd0 || st == 3'd1 || st == 3'd4 || st == 3'd5) ? 1'b0 : 1'b1;
      end else begin
        m_state = 0;
        m_dtr   = 1'b1;
      end
    end else begin
      // Leaving period m_pos: T1->T2, T2->T3, then T4 once waits are spent and ready is high.
      if (m_pos < 2)                                  m_state = m_pos + 2;
      else if (m_pos >= waits_for(m_cls) + 2 && rdy) m_state = 5;
      else                                            m_state = 4;
      m_pos++;
    end
    m_done = (m_state == 5) && (prev != 5);
  endtask

  function automatic logic [6:0] exp_cmds(input logic cen, input logic iob);
    logic early, late, mg, ig;
    early = (m_state == 2 || m_state == 3 || m_state == 4);
    late  = (m_state == 3 || m_state == 4);
    mg    = cen;
    ig    = cen | iob;
    return ~{early & mg & (m_cls == 3'd4 || m_cls == 3'd5),
             late  & mg & (m_cls == 3'd6),
             early & mg & (m_cls == 3'd6),
             early & ig & (m_cls == 3'd1),
             late  & ig & (m_cls == 3'd2),
             early & ig & (m_cls == 3'd2),
             early & ig & (m_cls == 3'd0)};
  endfunction

  function automatic logic exp_cpu_ready(input logic rdy);
    if ((m_state == 3 || m_state == 4) && !(m_pos >= waits_for(m_cls) + 2 && rdy)) return 1'b0;
    return 1'b1;
  endfunction

  logic obs_done;

  task automatic compare_all(input logic rdy, input logic cen, input logic iob, input logic aen);
    logic de;
    de = (m_state == 2 || m_state == 3 || m_state == 4);
    check("bus_state",  32'(bus_state),                       32'(m_state));
    check("ale",        32'(address_latch_enable),            32'(m_state == 1));
    check("mce",        32'(master_cascade_enable),           32'(m_state == 1 && m_cls == 3'd0));
    check("dt_r_n",     32'(direction_transmit_or_receive_n), 32'(m_dtr));
    check("den",        32'(data_enable),                     32'(de));
    check("pden_n",     32'(peripheral_data_enable_n),        32'(!de));
    check("cycle_done", 32'(cycle_done),                      32'(m_done));
    check("commands",   32'(cmds),                            32'(exp_cmds(cen, iob)));
    check("cpu_ready",  32'(cpu_ready),                       32'(exp_cpu_ready(rdy)));
    check("en_mem",     32'(enable_memory_command),           32'(!aen));
    check("en_io",      32'(enable_io_command),               32'(!aen | iob));
  endtask

  // One cpu_clock period: four system clocks, inputs applied with the rising cpu edge.
  task automatic cpu_period(input logic [2:0] st, input logic rdy, input logic cen,
                            input logic iob, input logic aen);
    @(negedge clock);
    processor_status = st;
    ready            = rdy;
    command_enable   = cen;
    io_bus_mode      = iob;
    address_enable_n = aen;
    cpu_clock        = 1'b1;
    model_step(st, rdy);
    @(posedge clock); #1;
    obs_done = cycle_done;
    compare_all(rdy, cen, iob, aen);
    @(posedge clock); #1;
    check("done_pulse_width", 32'(cycle_done), 32'd0);
    check("state_hold",       32'(bus_state),  32'(m_state));
    @(negedge clock);
    cpu_clock = 1'b0;
    @(negedge clock);
  endtask

  int seq_q[$];
  int cmd_low[7];
  int n_done, n_nrdy, n_mce;

  task automatic run_cycle(input logic [2:0] st_a, input int n_a, input logic [2:0] st_b,
                           input int n, input logic [31:0] rdy_mask, input logic cen,
                           input logic iob);
    seq_q.delete();
    for (int b = 0; b < 7; b++) cmd_low[b] = 0;
    n_done = 0;
    n_nrdy = 0;
    n_mce  = 0;
    for (int i = 0; i < n; i++) begin
      cpu_period((i < n_a) ? st_a : st_b, rdy_mask[i], cen, iob, 1'b0);
      seq_q.push_back(int'(bus_state));
      for (int b = 0; b < 7; b++) if (!cmds[b]) cmd_low[b]++;
      if (obs_done)              n_done++;
      if (!cpu_ready)            n_nrdy++;
      if (master_cascade_enable) n_mce++;
    end
  endtask

  int exp_memrd[5]  = '{1, 2, 3, 5, 0};
  int exp_iowr[6]   = '{1, 2, 3, 4, 5, 0};
  int exp_memwr[8]  = '{1, 2, 3, 4, 4, 4, 5, 0};
  int exp_b2b[9]    = '{1, 2, 3, 5, 1, 2, 3, 5, 0};

  initial begin
    reset_n          = 1'b0;
    cpu_clock        = 1'b0;
    address_enable_n = 1'b0;
    command_enable   = 1'b1;
    io_bus_mode      = 1'b0;
    processor_status = 3'b111;
    ready            = 1'b1;
    obs_done         = 1'b0;
    model_reset();

    repeat (3) @(posedge clock);
    #1;
    check("rst_bus_state", 32'(bus_state),                       32'd0);
    check("rst_cmds",      32'(cmds),                            32'h7F);
    check("rst_dt_r_n",    32'(direction_transmit_or_receive_n), 32'd1);
    check("rst_den",       32'(data_enable),                     32'd0);
    check("rst_pden_n",    32'(peripheral_data_enable_n),        32'd1);
    check("rst_ale",       32'(address_latch_enable),            32'd0);
    check("rst_mce",       32'(master_cascade_enable),           32'd0);
    check("rst_cpu_ready", 32'(cpu_ready),                       32'd1);
    check("rst_done",      32'(cycle_done),                      32'd0);
    check("rst_en_mem",    32'(enable_memory_command),           32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Memory read, no waits.
    run_cycle(3'b101, 1, 3'b111, 5, '1, 1'b1, 1'b0);
    foreach (exp_memrd[i]) check($sformatf("memrd_seq%0d", i), 32'(seq_q[i]), 32'(exp_memrd[i]));
    check("memrd_mrdc_periods", 32'(cmd_low[6]), 32'd2);
    check("memrd_done_pulses",  32'(n_done),     32'd1);

    // I/O write, one wait state.
    run_cycle(3'b010, 1, 3'b111, 6, '1, 1'b1, 1'b0);
    foreach (exp_iowr[i]) check($sformatf("iowr_seq%0d", i), 32'(seq_q[i]), 32'(exp_iowr[i]));
    check("iowr_aiowc_periods",   32'(cmd_low[1]), 32'd3);
    check("iowr_iowc_periods",    32'(cmd_low[2]), 32'd2);
    check("iowr_cpu_ready_low",   32'(n_nrdy),     32'd1);

    // Memory write stretched by ready low for three edges.
    run_cycle(3'b110, 1, 3'b111, 8, ~32'h3C, 1'b1, 1'b0);
    foreach (exp_memwr[i]) check($sformatf("memwr_seq%0d", i), 32'(seq_q[i]), 32'(exp_memwr[i]));
    check("memwr_mwtc_periods",   32'(cmd_low[5]), 32'd4);
    check("memwr_cpu_ready_low",  32'(n_nrdy),     32'd4);

    // INTA with CEN low: IOB=1 passes it, IOB=0 blocks it.
    run_cycle(3'b000, 1, 3'b111, 6, '1, 1'b0, 1'b1);
    check("inta_iob_periods", 32'(cmd_low[0]), 32'd3);
    check("inta_iob_mce",     32'(n_mce),      32'd1);
    run_cycle(3'b000, 1, 3'b111, 6, '1, 1'b0, 1'b0);
    check("inta_gated_periods", 32'(cmd_low[0]), 32'd0);
    check("inta_gated_mce",     32'(n_mce),      32'd1);

    // Halt keeps the bus idle.
    run_cycle(3'b011, 3, 3'b011, 3, '1, 1'b1, 1'b0);
    foreach (seq_q[i]) check($sformatf("halt_seq%0d", i), 32'(seq_q[i]), 32'd0);
    check("halt_cmd_periods", 32'(cmd_low[0] + cmd_low[1] + cmd_low[2] + cmd_low[3] +
                                  cmd_low[4] + cmd_low[5] + cmd_low[6]), 32'd0);

    // Back-to-back code fetches.
    run_cycle(3'b100, 8, 3'b111, 9, '1, 1'b1, 1'b0);
    foreach (exp_b2b[i]) check($sformatf("b2b_seq%0d", i), 32'(seq_q[i]), 32'(exp_b2b[i]));
    check("b2b_done_pulses", 32'(n_done), 32'd2);

    // Reset while an I/O read sits in TW.
    cpu_period(3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
    cpu_period(3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
    cpu_period(3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    cpu_period(3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    cpu_period(3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_reset_state", 32'(bus_state),         32'd4);
    check("pre_reset_iorc",  32'(io_read_command_n), 32'd0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_state",     32'(bus_state),         32'd0);
    check("midrst_iorc",      32'(io_read_command_n), 32'd1);
    check("midrst_cpu_ready", 32'(cpu_ready),         32'd1);
    check("midrst_den",       32'(data_enable),       32'd0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cpu_period(3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
    check("recover_state", 32'(bus_state), 32'd1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cpu_period(3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
